// File: rtl/di_xfw_operand_resolver.sv
// Cross-issue forwarding receiver: matches the other issue's EX/WB bundle against local ID operands,
// keeps WB results alive across local ID stalls, and stalls ID on a load-use hazard against the other issue.
module di_xfw_operand_resolver #(
  parameter int NUM_OPS = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        xfw_regfile_we_wb_i,
  input  logic                        xfw_regfile_alu_we_fw_i,
  input  logic [DATA_W-1:0]           xfw_regfile_alu_wdata_fw_i,
  input  logic [DATA_W-1:0]           xfw_regfile_wdata_wb_i,
  input  logic [ADDR_W-1:0]           xfw_regfile_waddr_ex_i,
  input  logic [ADDR_W-1:0]           xfw_regfile_waddr_wb_i,
  input  logic [ADDR_W-1:0]           xfw_regfile_alu_waddr_fw_i,
  input  logic                        xfw_load_ex_i,
  input  logic                        id_req_i,
  input  logic                        id_advance_i,
  input  logic [NUM_OPS*ADDR_W-1:0]   id_raddr_i,
  input  logic [NUM_OPS-1:0]          id_rused_i,
  output logic [NUM_OPS*2-1:0]        xfw_sel_o,
  output logic [NUM_OPS*DATA_W-1:0]   xfw_data_o,
  output logic                        xfw_stall_o
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           ld_addr_q, ld_addr_d;
  logic [NUM_OPS-1:0]          hold_vld_q, hold_vld_d;
  logic [NUM_OPS*DATA_W-1:0]   hold_dat_q, hold_dat_d;

  // While rst_n is low the outputs must already reflect cleared state.
  state_t                      state_eff;
  logic [ADDR_W-1:0]           ld_addr_eff;
  logic [NUM_OPS-1:0]          hold_vld_eff;

  logic [NUM_OPS-1:0]          alu_hit;
  logic [NUM_OPS-1:0]          wb_hit;
  logic [NUM_OPS-1:0]          ld_hit;
  logic [NUM_OPS-1:0]          wait_hit;
  logic [NUM_OPS-1:0]          alu_blocked;
  logic                        ld_wb_match;
  logic                        stall;

  always_comb begin
    state_eff    = rst_n ? state_q : IDLE;
    ld_addr_eff  = rst_n ? ld_addr_q : '0;
    hold_vld_eff = rst_n ? hold_vld_q : '0;

    alu_hit  = '0;
    wb_hit   = '0;
    ld_hit   = '0;
    wait_hit = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      logic [ADDR_W-1:0] ra;
      logic              act;
      ra          = id_raddr_i[i*ADDR_W +: ADDR_W];
      act         = id_req_i & id_rused_i[i] & (ra != '0);
      alu_hit[i]  = act & xfw_regfile_alu_we_fw_i & (ra == xfw_regfile_alu_waddr_fw_i);
      wb_hit[i]   = act & xfw_regfile_we_wb_i & (ra == xfw_regfile_waddr_wb_i);
      ld_hit[i]   = act & xfw_load_ex_i & (ra == xfw_regfile_waddr_ex_i);
      wait_hit[i] = act & (ra == ld_addr_eff);
    end
  end

  always_comb begin
    state_d     = state_eff;
    ld_addr_d   = ld_addr_eff;
    stall       = 1'b0;
    ld_wb_match = xfw_regfile_we_wb_i & (xfw_regfile_waddr_wb_i == ld_addr_eff);
    case (state_eff)
      IDLE: begin
        if (|ld_hit) begin
          stall     = 1'b1;
          state_d   = LD_WAIT;
          ld_addr_d = xfw_regfile_waddr_ex_i;
        end
      end
      LD_WAIT: begin
        // A flush or the load's WB both release the stall in the same cycle.
        if (!id_req_i || ld_wb_match) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The loaded value is not available yet, so an ALU result on that address must not be consumed.
  always_comb begin
    alu_blocked = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      alu_blocked[i] = stall & ((state_eff == IDLE) ? ld_hit[i] : wait_hit[i]);
    end
  end

  always_comb begin
    xfw_sel_o  = '0;
    xfw_data_o = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (alu_hit[i] && !alu_blocked[i]) begin
        xfw_sel_o[2*i +: 2]          = SEL_ALU;
        xfw_data_o[i*DATA_W +: DATA_W] = xfw_regfile_alu_wdata_fw_i;
      end else if (wb_hit[i]) begin
        xfw_sel_o[2*i +: 2]          = SEL_WB;
        xfw_data_o[i*DATA_W +: DATA_W] = xfw_regfile_wdata_wb_i;
      end else if (hold_vld_eff[i]) begin
        xfw_sel_o[2*i +: 2]          = SEL_HOLD;
        xfw_data_o[i*DATA_W +: DATA_W] = hold_dat_q[i*DATA_W +: DATA_W];
      end else begin
        xfw_sel_o[2*i +: 2]          = SEL_NONE;
      end
    end
    xfw_stall_o = stall;
  end

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (!id_req_i || id_advance_i) begin
      hold_vld_d = '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (wb_hit[i]) begin
          hold_vld_d[i]                  = 1'b1;
          hold_dat_d[i*DATA_W +: DATA_W] = xfw_regfile_wdata_wb_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_addr_q  <= '0;
      hold_vld_q <= '0;
      hold_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end

endmodule

// File: tb/tb_di_xfw_operand_resolver.sv
// Directed vectors for the cross-issue operand resolver; expected responses go through a scoreboard queue.
module tb_di_xfw_operand_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_wb, alu_we, load_ex, id_req, id_adv;
  logic [31:0] alu_wdata, wdata_wb;
  logic [5:0]  waddr_ex, waddr_wb, alu_waddr;
  logic [17:0] raddr;
  logic [2:0]  rused;
  logic [5:0]  sel;
  logic [95:0] data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  logic [5:0]  q_sel[$];
  logic [95:0] q_dat[$];
  logic        q_stl[$];
  string       q_nm[$];

  always #5 clk = ~clk;

  di_xfw_operand_resolver dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .xfw_regfile_we_wb_i        (we_wb),
    .xfw_regfile_alu_we_fw_i    (alu_we),
    .xfw_regfile_alu_wdata_fw_i (alu_wdata),
    .xfw_regfile_wdata_wb_i     (wdata_wb),
    .xfw_regfile_waddr_ex_i     (waddr_ex),
    .xfw_regfile_waddr_wb_i     (waddr_wb),
    .xfw_regfile_alu_waddr_fw_i (alu_waddr),
    .xfw_load_ex_i              (load_ex),
    .id_req_i                   (id_req),
    .id_advance_i               (id_adv),
    .id_raddr_i                 (raddr),
    .id_rused_i                 (rused),
    .xfw_sel_o                  (sel),
    .xfw_data_o                 (data),
    .xfw_stall_o                (stall)
  );

  function automatic logic [17:0] ra(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [95:0] dd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    return {d2, d1, d0};
  endfunction

  task automatic idle_inputs();
    we_wb = 0; alu_we = 0; load_ex = 0;
    alu_wdata = 0; wdata_wb = 0;
    waddr_ex = 0; waddr_wb = 0; alu_waddr = 0;
  endtask

  // Inputs for this cycle are already applied; queue the expectation and move to the next cycle.
  task automatic expect_cyc(input string nm, input logic [5:0] s, input logic [95:0] d, input logic st);
    q_nm.push_back(nm);
    q_sel.push_back(s);
    q_dat.push_back(d);
    q_stl.push_back(st);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q_nm.size() > 0) begin
      string       nm;
      logic [5:0]  es;
      logic [95:0] ed;
      logic        est;
      nm  = q_nm.pop_front();
      es  = q_sel.pop_front();
      ed  = q_dat.pop_front();
      est = q_stl.pop_front();
      checks++;
      if (sel !== es) begin
        errors++;
        $display("FAIL %s sel got %b want %b", nm, sel, es);
      end
      checks++;
      if (data !== ed) begin
        errors++;
        $display("FAIL %s data got %h want %h", nm, data, ed);
      end
      checks++;
      if (stall !== est) begin
        errors++;
        $display("FAIL %s stall got %b want %b", nm, stall, est);
      end
    end
  end

  initial begin
    rst_n = 0; id_req = 0; id_adv = 0; raddr = 0; rused = 0;
    idle_inputs();
    @(posedge clk); #1;
    expect_cyc("reset_idle", 6'b000000, 96'h0, 1'b0);
    // the IDLE-cycle load term is live even in reset
    id_req = 1; raddr = ra(6'd0, 6'd3, 6'd0); rused = 3'b010; load_ex = 1; waddr_ex = 6'd3;
    expect_cyc("reset_ld_term", 6'b000000, 96'h0, 1'b1);
    idle_inputs();
    expect_cyc("reset_quiet", 6'b000000, 96'h0, 1'b0);
    rst_n = 1;

    // 1: basic EX-ALU forward
    id_req = 1; id_adv = 1; raddr = ra(6'd5, 6'd0, 6'd0); rused = 3'b001;
    alu_we = 1; alu_waddr = 6'd5; alu_wdata = 32'hA5A5;
    expect_cyc("alu_fwd", 6'b000001, dd(32'hA5A5, 0, 0), 1'b0);

    // 2: ALU beats WB; x0 never matches; FP bank matches
    idle_inputs();
    raddr = ra(6'd7, 6'd0, 6'd0); rused = 3'b001;
    alu_we = 1; alu_waddr = 6'd7; alu_wdata = 32'h11;
    we_wb = 1; waddr_wb = 6'd7; wdata_wb = 32'h22;
    expect_cyc("alu_over_wb", 6'b000001, dd(32'h11, 0, 0), 1'b0);
    idle_inputs();
    raddr = ra(6'd0, 6'd7, 6'd0); rused = 3'b011;
    alu_we = 1; alu_waddr = 6'd0; alu_wdata = 32'h33;
    we_wb = 1; waddr_wb = 6'd7; wdata_wb = 32'h22;
    expect_cyc("x0_and_wb", 6'b001000, dd(0, 32'h22, 0), 1'b0);
    idle_inputs();
    raddr = ra(6'd0, 6'd0, 6'h25); rused = 3'b100;
    alu_we = 1; alu_waddr = 6'h25; alu_wdata = 32'h44;
    expect_cyc("fp_alu", 6'b010000, dd(0, 0, 32'h44), 1'b0);

    // 3: hold register capture, reuse, clear
    idle_inputs(); id_adv = 0;
    raddr = ra(6'd9, 6'd0, 6'd0); rused = 3'b001;
    we_wb = 1; waddr_wb = 6'd9; wdata_wb = 32'hBEEF;
    expect_cyc("hold_wb", 6'b000010, dd(32'hBEEF, 0, 0), 1'b0);
    idle_inputs();
    expect_cyc("hold_use", 6'b000011, dd(32'hBEEF, 0, 0), 1'b0);
    id_adv = 1;
    expect_cyc("hold_adv_cycle", 6'b000011, dd(32'hBEEF, 0, 0), 1'b0);
    expect_cyc("hold_cleared", 6'b000000, 96'h0, 1'b0);
    id_adv = 0;
    alu_we = 1; alu_waddr = 6'd9; alu_wdata = 32'h55;
    expect_cyc("alu_no_capture", 6'b000001, dd(32'h55, 0, 0), 1'b0);
    idle_inputs();
    expect_cyc("alu_no_capture2", 6'b000000, 96'h0, 1'b0);
    we_wb = 1; waddr_wb = 6'd9; wdata_wb = 32'h1;
    expect_cyc("hold_ow1", 6'b000010, dd(32'h1, 0, 0), 1'b0);
    wdata_wb = 32'h2;
    expect_cyc("hold_ow2", 6'b000010, dd(32'h2, 0, 0), 1'b0);
    idle_inputs();
    expect_cyc("hold_ow_use", 6'b000011, dd(32'h2, 0, 0), 1'b0);
    id_adv = 1;
    expect_cyc("hold_ow_adv", 6'b000011, dd(32'h2, 0, 0), 1'b0);

    // 4: load-use with same-address ALU hit, released by WB next cycle
    idle_inputs(); id_adv = 0;
    raddr = ra(6'd0, 6'd3, 6'd0); rused = 3'b010;
    load_ex = 1; waddr_ex = 6'd3;
    alu_we = 1; alu_waddr = 6'd3; alu_wdata = 32'h99;
    expect_cyc("ld_stall_alu", 6'b000000, 96'h0, 1'b1);
    idle_inputs(); id_adv = 1;
    we_wb = 1; waddr_wb = 6'd3; wdata_wb = 32'h1234;
    expect_cyc("ld_release", 6'b001000, dd(0, 32'h1234, 0), 1'b0);
    idle_inputs(); id_adv = 0;
    expect_cyc("ld_idle_after", 6'b000000, 96'h0, 1'b0);

    // 5: WB delayed 3 cycles -> 4 stall cycles
    load_ex = 1; waddr_ex = 6'd3;
    expect_cyc("ld5_c0", 6'b000000, 96'h0, 1'b1);
    idle_inputs();
    expect_cyc("ld5_c1", 6'b000000, 96'h0, 1'b1);
    we_wb = 1; waddr_wb = 6'd4; wdata_wb = 32'h77;
    expect_cyc("ld5_c2_otherwb", 6'b000000, 96'h0, 1'b1);
    idle_inputs();
    expect_cyc("ld5_c3", 6'b000000, 96'h0, 1'b1);
    we_wb = 1; waddr_wb = 6'd3; wdata_wb = 32'hCAFE; id_adv = 1;
    expect_cyc("ld5_release", 6'b001000, dd(0, 32'hCAFE, 0), 1'b0);

    // 5b: reset pulse in LD_WAIT with a live hold entry
    idle_inputs(); id_adv = 0;
    raddr = ra(6'd9, 6'd3, 6'd0); rused = 3'b011;
    load_ex = 1; waddr_ex = 6'd3;
    expect_cyc("ld5r_c0", 6'b000000, 96'h0, 1'b1);
    idle_inputs();
    we_wb = 1; waddr_wb = 6'd9; wdata_wb = 32'hBEEF;
    expect_cyc("ld5r_wait_cap", 6'b000010, dd(32'hBEEF, 0, 0), 1'b1);
    idle_inputs(); rst_n = 0;
    expect_cyc("ld5r_in_reset", 6'b000000, 96'h0, 1'b0);
    rst_n = 1;
    expect_cyc("ld5r_after", 6'b000000, 96'h0, 1'b0);

    // 6: flush in LD_WAIT; capture and clear in the same cycle
    raddr = ra(6'd0, 6'd3, 6'd0); rused = 3'b010;
    load_ex = 1; waddr_ex = 6'd3;
    expect_cyc("ld6_c0", 6'b000000, 96'h0, 1'b1);
    idle_inputs();
    expect_cyc("ld6_wait", 6'b000000, 96'h0, 1'b1);
    id_req = 0;
    expect_cyc("ld6_flush", 6'b000000, 96'h0, 1'b0);
    id_req = 1;
    expect_cyc("ld6_idle", 6'b000000, 96'h0, 1'b0);
    raddr = ra(6'd9, 6'd0, 6'd0); rused = 3'b001; id_adv = 1;
    we_wb = 1; waddr_wb = 6'd9; wdata_wb = 32'hD00D;
    expect_cyc("cap_clr_same", 6'b000010, dd(32'hD00D, 0, 0), 1'b0);
    idle_inputs(); id_adv = 0;
    expect_cyc("cap_clr_after", 6'b000000, 96'h0, 1'b0);

    for (int i = 0; i < 10 && q_nm.size() > 0; i++) @(negedge clk);
    if (q_nm.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q_nm.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
